// File: rtl/skidreg_pkg.sv
// Shared ready/valid (dti) definitions: buffer state encoding and small
// state-decoding helpers reused by buffering blocks and their benches.
package dti_pkg;

  localparam int unsigned DTI_W_DEFAULT = 16;

  // 2'b11 is deliberately left unused; blocks treat it as illegal.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b01,
    FULL  = 2'b10
  } skidreg_state_t;

  function automatic logic state_has_word(input skidreg_state_t s);
    return (s == HALF) || (s == FULL);
  endfunction

  function automatic logic state_can_accept(input skidreg_state_t s);
    return (s == EMPTY) || (s == HALF);
  endfunction

endpackage

// File: rtl/skidreg_if.sv
// Ready/valid handshake bundle; the producer drives data/valid and the
// consumer drives ready.
interface dti #(
  parameter int unsigned W = 16
) ();

  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport producer (
    output data,
    output valid,
    input  ready
  );

  modport consumer (
    input  data,
    input  valid,
    output ready
  );

  modport monitor (
    input data,
    input valid,
    input ready
  );

endinterface

// File: rtl/skidreg.sv
// Fully registered two-entry skid buffer: din.ready and dout.valid/data come
// straight from flops, so the block breaks timing paths in both directions.
module skidreg
  import dti_pkg::*;
#(
  parameter int unsigned    DIN  = 16,
  parameter logic [DIN-1:0] INIT = '0
) (
  input logic   clk,
  input logic   rst,
  dti.consumer  din,
  dti.producer  dout
);

  skidreg_state_t state_q;
  skidreg_state_t state_d;

  logic [DIN-1:0] main_q;
  logic [DIN-1:0] skid_q;
  logic           valid_q;
  logic           ready_q;

  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (din.valid) begin
          load_main_in = 1'b1;
          state_d      = HALF;
        end
      end
      HALF: begin
        case ({din.valid, dout.ready})
          2'b11: load_main_in = 1'b1;
          2'b10: begin
            load_skid = 1'b1;
            state_d   = FULL;
          end
          2'b01:   state_d = EMPTY;
          default: state_d = HALF;
        endcase
      end
      FULL: begin
        if (dout.ready) begin
          load_main_skid = 1'b1;
          state_d        = HALF;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Handshake outputs are registered from the next state rather than decoded
  // from the current one, keeping them one flop away from any input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      valid_q <= state_has_word(state_d);
      ready_q <= state_can_accept(state_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= INIT;
    end else if (load_main_in) begin
      main_q <= din.data;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
  end

  // skid is never visible on dout until copied to main, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_q <= din.data;
    end
  end

  assign din.ready  = ready_q;
  assign dout.valid = valid_q;
  assign dout.data  = main_q;

endmodule

// File: tb/tb_skidreg.sv
// Directed and random self-checking bench for skidreg (DIN=16).
module tb_skidreg;
  import dti_pkg::*;

  localparam logic [15:0] INIT_V = 16'hC3C3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  dti #(.W(16)) din_if ();
  dti #(.W(16)) dout_if ();

  skidreg #(
    .DIN  (16),
    .INIT (INIT_V)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din_if),
    .dout (dout_if)
  );

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [15:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned popped;
    int unsigned cyc;
    logic        v;
    logic        r;
    logic        acc;
    logic        pop;
    logic [15:0] d;

    din_if.valid  = 1'b0;
    din_if.data   = '0;
    dout_if.ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(dout_if.valid), 32'd0);
    chk("rst_ready", 32'(din_if.ready), 32'd1);
    chk("rst_data", 32'(dout_if.data), 32'(INIT_V));
    chk("rst_state", 32'(dut.state_q), 32'(EMPTY));
    step();
    step();
    rst = 1'b0;

    // streaming
    dout_if.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      din_if.valid = 1'b1;
      din_if.data  = 16'(i);
      step();
      chk("stream_data", 32'(dout_if.data), 32'(i));
      chk("stream_valid", 32'(dout_if.valid), 32'd1);
      chk("stream_ready", 32'(din_if.ready), 32'd1);
    end
    din_if.valid = 1'b0;
    din_if.data  = 16'hDEAD;
    step();
    chk("stream_end_valid", 32'(dout_if.valid), 32'd0);
    chk("stream_end_state", 32'(dut.state_q), 32'(EMPTY));
    chk("no_capture", 32'(dout_if.data), 32'h0008);

    // backpressure
    dout_if.ready = 1'b0;
    din_if.valid  = 1'b1;
    din_if.data   = 16'hAAAA;
    step();
    chk("bp_half", 32'(dut.state_q), 32'(HALF));
    chk("bp_data0", 32'(dout_if.data), 32'hAAAA);
    chk("bp_ready0", 32'(din_if.ready), 32'd1);
    din_if.data = 16'hBBBB;
    step();
    chk("bp_full", 32'(dut.state_q), 32'(FULL));
    chk("bp_ready1", 32'(din_if.ready), 32'd0);
    chk("bp_data1", 32'(dout_if.data), 32'hAAAA);
    din_if.data = 16'hDEAD;
    step();
    chk("bp_hold_state", 32'(dut.state_q), 32'(FULL));
    chk("bp_hold_data", 32'(dout_if.data), 32'hAAAA);
    chk("bp_hold_valid", 32'(dout_if.valid), 32'd1);
    din_if.valid  = 1'b0;
    dout_if.ready = 1'b1;
    step();
    chk("bp_drain_data", 32'(dout_if.data), 32'hBBBB);
    chk("bp_drain_ready", 32'(din_if.ready), 32'd1);
    chk("bp_drain_state", 32'(dut.state_q), 32'(HALF));
    step();
    chk("bp_empty_valid", 32'(dout_if.valid), 32'd0);
    chk("bp_empty_state", 32'(dut.state_q), 32'(EMPTY));

    // random traffic against an occupancy/order model
    popped = 0;
    cyc    = 0;
    while (popped < 10000 && cyc < 60000) begin
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      din_if.valid  = v;
      din_if.data   = d;
      dout_if.ready = r;
      #1;
      chk("rnd_valid", 32'(dout_if.valid), 32'(sb.size() != 0));
      chk("rnd_ready", 32'(din_if.ready), 32'(sb.size() < 2));
      acc = v && (sb.size() < 2);
      pop = r && (sb.size() != 0);
      if (pop) begin
        chk("rnd_data", 32'(dout_if.data), 32'(sb[0]));
        void'(sb.pop_front());
        popped++;
      end
      if (acc) sb.push_back(d);
      step();
      cyc++;
    end
    chk("rnd_words", popped, 32'd10000);
    din_if.valid  = 1'b0;
    dout_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (sb.size() != 0) begin
        chk("drain_data", 32'(dout_if.data), 32'(sb[0]));
        void'(sb.pop_front());
      end
      step();
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
    chk("drain_valid", 32'(dout_if.valid), 32'd0);

    // asynchronous reset while FULL
    dout_if.ready = 1'b0;
    din_if.valid  = 1'b1;
    din_if.data   = 16'h1234;
    step();
    din_if.data = 16'h5678;
    step();
    chk("rst_pre_full", 32'(dut.state_q), 32'(FULL));
    din_if.valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(dout_if.valid), 32'd0);
    chk("arst_ready", 32'(din_if.ready), 32'd1);
    chk("arst_state", 32'(dut.state_q), 32'(EMPTY));
    chk("arst_data", 32'(dout_if.data), 32'(INIT_V));
    #2 rst = 1'b0;
    din_if.valid  = 1'b1;
    din_if.data   = 16'h9ABC;
    dout_if.ready = 1'b1;
    step();
    chk("post_rst_data", 32'(dout_if.data), 32'h9ABC);
    chk("post_rst_valid", 32'(dout_if.valid), 32'd1);
    din_if.valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_idle", 32'(dout_if.valid), 32'd0);
      chk("post_rst_keep", 32'(dout_if.data), 32'h9ABC);
    end

    // isolated words with idle gaps
    for (int w = 0; w < 3; w++) begin
      din_if.valid = 1'b1;
      din_if.data  = 16'h00FF;
      step();
      chk("gap_half", 32'(dut.state_q), 32'(HALF));
      chk("gap_valid_hi", 32'(dout_if.valid), 32'd1);
      chk("gap_data", 32'(dout_if.data), 32'h00FF);
      din_if.valid = 1'b0;
      step();
      chk("gap_empty", 32'(dut.state_q), 32'(EMPTY));
      chk("gap_valid_lo", 32'(dout_if.valid), 32'd0);
      step();
      step();
      chk("gap_idle", 32'(dout_if.valid), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
